irq_ctrl: RTL

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source gateways, enable mask, claim/complete register interface, meip output.
// Latency: register reads return one cycle after the access; meip follows pending&enable by one cycle.
// Backpressure: none; one access per cycle is always accepted. Build option IRQ_CTRL_EDGE_EN selects edge-triggered requests.
module irq_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               bus_valid,
    input  logic               bus_write,
    input  logic [1:0]         bus_addr,
    input  logic [31:0]        bus_wdata,
    output logic [31:0]        bus_rdata,
    output logic               bus_rvalid,
    output logic               meip
);

    typedef enum logic [1:0] {
        GW_IDLE       = 2'd0,
        GW_PENDING    = 2'd1,
        GW_IN_SERVICE = 2'd2
    } gw_state_t;

    gw_state_t          gw_q [NUM_SRC];
    gw_state_t          gw_d [NUM_SRC];
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               meip_q, meip_d;

    logic [NUM_SRC-1:0] pending, in_service, req, claimable;
    logic               rd_en, claim_rd, cpl_wr, en_wr;
    logic               claim_hit;
    logic [4:0]         claim_idx, claim_id, cpl_id;
    logic               unused_wdata;

    assign unused_wdata = ^bus_wdata;

    assign rd_en    = bus_valid & ~bus_write;
    assign claim_rd = rd_en & (bus_addr == 2'd2);
    assign cpl_wr   = bus_valid & bus_write & (bus_addr == 2'd2);
    assign en_wr    = bus_valid & bus_write & (bus_addr == 2'd1);
    assign cpl_id   = bus_wdata[4:0];

`ifdef IRQ_CTRL_EDGE_EN
    logic [NUM_SRC-1:0] src_prev_q, src_prev_d;

    assign src_prev_d = irq_src;
    assign req        = irq_src & ~src_prev_q;

    // Previous source level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) src_prev_q <= '0;
        else       src_prev_q <= src_prev_d;
    end
`else
    assign req = irq_src;
`endif

    // Decode gateway states into the pending / in-service bit vectors.
    always_comb begin
        pending    = '0;
        in_service = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pending[i]    = (gw_q[i] == GW_PENDING);
            in_service[i] = (gw_q[i] == GW_IN_SERVICE);
        end
    end

    assign claimable = pending & enable_q;

    // Lowest-ID arbitration over registered pending & enable.
    always_comb begin
        claim_hit = 1'b0;
        claim_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (claimable[i]) begin
                claim_hit = 1'b1;
                claim_idx = 5'(i);
            end
        end
    end

    assign claim_id = claim_hit ? (claim_idx + 5'd1) : 5'd0;

    // Gateway transitions; a request is only taken from IDLE, so a request
    // coinciding with complete of the same source is dropped.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            gw_d[i] = gw_q[i];
            case (gw_q[i])
                GW_IDLE:       if (req[i]) gw_d[i] = GW_PENDING;
                GW_PENDING:    if (claim_rd && claim_hit && claim_idx == 5'(i)) gw_d[i] = GW_IN_SERVICE;
                GW_IN_SERVICE: if (cpl_wr && cpl_id == 5'(i + 1)) gw_d[i] = GW_IDLE;
                default:       gw_d[i] = GW_IDLE;
            endcase
        end
    end

    // Enable register, read data mux (held when idle) and meip.
    always_comb begin
        enable_d = enable_q;
        if (en_wr) enable_d = bus_wdata[NUM_SRC-1:0];

        rvalid_d = rd_en;
        rdata_d  = rdata_q;
        if (rd_en) begin
            case (bus_addr)
                2'd0:    rdata_d = 32'(pending);
                2'd1:    rdata_d = 32'(enable_q);
                2'd2:    rdata_d = 32'(claim_id);
                default: rdata_d = 32'(in_service);
            endcase
        end

        meip_d = |(pending & enable_q);
    end

    // State registers; reset wins over any concurrent access or request.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) gw_q[i] <= GW_IDLE;
            enable_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            meip_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) gw_q[i] <= gw_d[i];
            enable_q <= enable_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            meip_q   <= meip_d;
        end
    end

    assign bus_rdata  = rdata_q;
    assign bus_rvalid = rvalid_q;
    assign meip       = meip_q;

endmodule
